// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry and Gray/binary pointer helpers.
// Used by the read-side stream controller and the write-side pointer block.
package fifo_pkg;

    localparam int unsigned FIFO_DATASIZE = 8;
    localparam int unsigned FIFO_ADDRSIZE = 4;

    // Pointers are carried zero-extended to this width; w selects the live bits
    localparam int unsigned PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_t;

    // Binary to Gray for a w-bit pointer
    function automatic ptr_t bin2gray(input ptr_t b, input int unsigned w);
        ptr_t m;
        ptr_t bm;
        m  = (w >= PTR_MAX_W) ? '1 : ((ptr_t'(1) << w) - ptr_t'(1));
        bm = b & m;
        return bm ^ (bm >> 1);
    endfunction

    // Gray to binary for a w-bit pointer: XOR prefix from the MSB down
    function automatic ptr_t gray2bin(input ptr_t g, input int unsigned w);
        ptr_t b;
        logic acc;
        b   = '0;
        acc = 1'b0;
        for (int i = PTR_MAX_W - 1; i >= 0; i--) begin
            if (i < int'(w)) begin
                acc  = acc ^ g[i];
                b[i] = acc;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// W-bit Gray-to-binary converter (combinational XOR prefix).
module fifo_gray2bin
    import fifo_pkg::*;
#(
    parameter int unsigned W = FIFO_ADDRSIZE + 1
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin_c
);

    // Convert through the shared helper at the configured width
    always_comb begin
        bin_c = W'(gray2bin(PTR_MAX_W'(gray), W));
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side FIFO controller: owns the read pointer and empty flag, drives the
// asynchronous memory read address and presents popped words on a
// valid/ready stream master port.
// Optional feature: define FIFO_RD_LEVEL_EN to produce a registered fill level
// on rlevel; otherwise rlevel is tied to zero.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int unsigned DATASIZE = FIFO_DATASIZE,
    parameter int unsigned ADDRSIZE = FIFO_ADDRSIZE
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [DATASIZE-1:0] rdata,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic [DATASIZE-1:0] m_tdata,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic [ADDRSIZE:0]   rlevel
);

    localparam int unsigned PW = ADDRSIZE + 1;

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbinnext;
    logic [PW-1:0] rgraynext;
    logic          pop;

    // Pop whenever memory holds a word and the output register is free or draining
    always_comb begin
        pop       = !rempty && (!m_tvalid || m_tready);
        rbinnext  = rbin + PW'(pop);
        rgraynext = PW'(bin2gray(PTR_MAX_W'(rbinnext), PW));
    end

    assign raddr = rbin[ADDRSIZE-1:0];

    // Pointer, empty flag and output register
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin     <= '0;
            rptr     <= '0;
            rempty   <= 1'b1;
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
        end else begin
            rbin     <= rbinnext;
            rptr     <= rgraynext;
            rempty   <= (rgraynext == rq2_wptr);
            m_tvalid <= pop || (m_tvalid && !m_tready);
            if (pop) begin
                m_tdata <= rdata;
            end
        end
    end

`ifdef FIFO_RD_LEVEL_EN
    logic [PW-1:0] wbin;

    fifo_gray2bin #(
        .W(PW)
    ) u_wptr_g2b (
        .gray  (rq2_wptr),
        .bin_c (wbin)
    );

    // Words left in memory after this edge's pop, modulo pointer range
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rlevel <= '0;
        end else begin
            rlevel <= wbin - rbinnext;
        end
    end
`else
    assign rlevel = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream: directed scenarios plus a randomized stream
// checked against a queue-based model of the FIFO contents.
`timescale 1ns/1ps
module tb_fifo_rd_stream;

    logic       rclk;
    logic       rrst;
    logic [4:0] rq2_wptr;
    logic [7:0] rdata;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic [4:0] rlevel;

    logic [7:0] mem [16];
    logic [7:0] exp_q [$];
    int         wcount;
    int         delivered;
    int         checks;
    int         errors;

    fifo_rd_stream #(.DATASIZE(8), .ADDRSIZE(4)) dut (
        .rclk     (rclk),
        .rrst     (rrst),
        .rq2_wptr (rq2_wptr),
        .rdata    (rdata),
        .raddr    (raddr),
        .rptr     (rptr),
        .rempty   (rempty),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .rlevel   (rlevel)
    );

    assign rdata = mem[raddr];

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic logic [4:0] gray(input int n);
        int m;
        m = n % 32;
        return 5'(m ^ (m >> 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [7:0] d);
        mem[wcount % 16] = d;
        exp_q.push_back(d);
        wcount++;
        rq2_wptr = gray(wcount);
    endtask

    // One clock with scoreboard and invariant checks
    task automatic cycle();
        logic       held;
        logic [7:0] hd;
        logic [3:0] ha;
        logic [4:0] hp;
        int         popped;
        held = 1'b0;
        hd = '0; ha = '0; hp = '0;
        if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            if (exp_q.size() == 0) chk("extra_word", 32'd1, 32'd0);
            else chk("order", 32'(m_tdata), 32'(exp_q.pop_front()));
            delivered++;
        end
        if (m_tvalid === 1'b1 && m_tready === 1'b0) begin
            held = 1'b1; hd = m_tdata; ha = raddr; hp = rptr;
        end
        @(posedge rclk); #1;
        if (held) begin
            chk("hold_valid", 32'(m_tvalid), 32'd1);
            chk("hold_data",  32'(m_tdata),  32'(hd));
            chk("hold_raddr", 32'(raddr),    32'(ha));
            chk("hold_rptr",  32'(rptr),     32'(hp));
        end
        popped = delivered + int'(m_tvalid);
        chk("rptr", 32'(rptr), 32'(gray(popped)));
        if (rempty === 1'b0) chk("not_optimistic", 32'(popped < wcount), 32'd1);
`ifndef FIFO_RD_LEVEL_EN
        chk("rlevel_zero", 32'(rlevel), 32'd0);
`endif
    endtask

    task automatic do_reset();
        rrst = 1'b1;
        rq2_wptr = 5'($urandom_range(0, 31));
        m_tready = 1'($urandom_range(0, 1));
        repeat (2) begin @(posedge rclk); #1; end
        exp_q.delete();
        wcount = 0;
        delivered = 0;
        rq2_wptr = 5'd0;
        rrst = 1'b0;
    endtask

    initial begin
        int  n;
        int  popped;
        logic saw16;
        logic saw32;
        checks = 0; errors = 0; wcount = 0; delivered = 0;
        rrst = 1'b1; rq2_wptr = '0; m_tready = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        // 1. Reset values, checked while reset is held with random wptr
        rrst = 1'b1;
        rq2_wptr = 5'($urandom_range(0, 31));
        repeat (2) begin @(posedge rclk); #1; end
        chk("rst_rempty", 32'(rempty),   32'd1);
        chk("rst_valid",  32'(m_tvalid), 32'd0);
        chk("rst_raddr",  32'(raddr),    32'd0);
        chk("rst_rptr",   32'(rptr),     32'd0);
        chk("rst_rlevel", 32'(rlevel),   32'd0);
        chk("rst_tdata",  32'(m_tdata),  32'd0);
        rq2_wptr = 5'd0;
        rrst = 1'b0;

        // 2. Single word: two-edge latency, then empty again
        m_tready = 1'b1;
        write_word(8'hA5);
        chk("sw_wptr", 32'(rq2_wptr), 32'h01);
        cycle();
        chk("sw_e1_rempty", 32'(rempty),   32'd0);
        chk("sw_e1_valid",  32'(m_tvalid), 32'd0);
        cycle();
        chk("sw_e2_valid",  32'(m_tvalid), 32'd1);
        chk("sw_e2_data",   32'(m_tdata),  32'hA5);
        chk("sw_e2_rptr",   32'(rptr),     32'h01);
        chk("sw_e2_rempty", 32'(rempty),   32'd1);
        cycle();
        chk("sw_e3_valid",  32'(m_tvalid), 32'd0);

        // 3. Backpressure: one pop only, then drain back-to-back
        do_reset();
        m_tready = 1'b0;
        write_word(8'h11); write_word(8'h22); write_word(8'h33);
        chk("bp_wptr", 32'(rq2_wptr), 32'h02);
        repeat (5) cycle();
        chk("bp_valid", 32'(m_tvalid), 32'd1);
        chk("bp_data",  32'(m_tdata),  32'h11);
        chk("bp_raddr", 32'(raddr),    32'd1);
        m_tready = 1'b1;
        cycle();
        chk("bp_d2", 32'(m_tdata), 32'h22);
        cycle();
        chk("bp_d3", 32'(m_tdata), 32'h33);
        chk("bp_empty", 32'(rempty), 32'd1);
        cycle();
        chk("bp_drained", 32'(m_tvalid), 32'd0);
        chk("bp_q_empty", 32'(exp_q.size()), 32'd0);

        // 4. Wrap: 40 random words, random ready, random write pacing
        do_reset();
        saw16 = 1'b0; saw32 = 1'b0;
        n = 0;
        while (delivered < 40 && n < 3000) begin
            if (wcount < 40 && (wcount - delivered) < 16 && $urandom_range(0, 3) != 0)
                write_word(8'($urandom_range(0, 255)));
            m_tready = 1'($urandom_range(0, 1));
            cycle();
            popped = delivered + int'(m_tvalid);
            if (popped == 16 && !saw16) begin
                saw16 = 1'b1;
                chk("wrap_msb16", 32'(rptr[4]), 32'd1);
            end
            if (popped == 32 && !saw32) begin
                saw32 = 1'b1;
                chk("wrap_msb32", 32'(rptr[4]), 32'd0);
            end
            n++;
        end
        chk("wrap_timeout", 32'(delivered), 32'd40);
        cycle();
        chk("wrap_final_rptr", 32'(rptr),     32'h0C);
        chk("wrap_final_wptr", 32'(rq2_wptr), 32'h0C);
        chk("wrap_rempty",     32'(rempty),   32'd1);
        chk("wrap_seen_16_32", 32'({saw16, saw32}), 32'd3);

        // 5. Reset while a word is held under backpressure
        do_reset();
        m_tready = 1'b0;
        write_word(8'h5C); write_word(8'hC5);
        n = 0;
        while (m_tvalid !== 1'b1 && n < 10) begin cycle(); n++; end
        chk("mr_valid_before", 32'(m_tvalid), 32'd1);
        rrst = 1'b1;
        rq2_wptr = 5'd0;
        @(posedge rclk); #1;
        chk("mr_valid", 32'(m_tvalid), 32'd0);
        chk("mr_rptr",  32'(rptr),     32'd0);
        chk("mr_empty", 32'(rempty),   32'd1);
        exp_q.delete(); wcount = 0; delivered = 0;
        rrst = 1'b0;
        m_tready = 1'b1;
        repeat (5) begin
            cycle();
            chk("mr_no_delivery", 32'(m_tvalid), 32'd0);
        end

        // 6. Level with five words written and one popped into the output register
        do_reset();
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) write_word(8'(8'h40 + i));
        chk("lv_wptr", 32'(rq2_wptr), 32'h07);
        repeat (4) cycle();
        chk("lv_valid", 32'(m_tvalid), 32'd1);
`ifdef FIFO_RD_LEVEL_EN
        chk("lv_level", 32'(rlevel), 32'(wcount - 1));
`else
        chk("lv_level", 32'(rlevel), 32'd0);
`endif
        m_tready = 1'b1;
        n = 0;
        while (delivered < 5 && n < 50) begin cycle(); n++; end
        chk("lv_drain", 32'(delivered), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
